// File: rtl/divider_scheduler.sv
// divider_scheduler: programmable clock divider with glitch-free reconfiguration.
//
// Produces a registered divided clock (clockout) whose period is N clockin cycles and whose
// high-time is H cycles. A new (N, H) may be offered at any time through a valid/ready
// handshake. While running, an accepted configuration waits in a single pending slot and is
// applied only at a period boundary, so every emitted period uses one consistent (N, H).
// Dropping enable lets the current period finish before returning to idle.
//
// Ports:
//   clockin      in   single clock, all logic on its rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   request the divided clock to run
//   cfg_valid    in   new configuration offered
//   cfg_ratio    in   requested divide ratio N (WIDTH bits)
//   cfg_high     in   requested high-time H in clockin cycles (WIDTH bits)
//   cfg_ready    out  configuration can be accepted
//   cfg_err      out  one-cycle pulse: offered configuration was rejected
//   clockout     out  registered divided clock
//   period_done  out  one-cycle pulse on the last cycle of each period
//   active       out  high while running or draining
module divider_scheduler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEF_RATIO = 2,
  parameter int unsigned DEF_HIGH  = 1
) (
  input  logic             clockin,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_ratio,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clockout,
  output logic             period_done,
  output logic             active
);

  localparam logic [WIDTH-1:0] Zero = '0;
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);
  localparam logic [WIDTH-1:0] Two  = WIDTH'(2);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] pratio_q, pratio_d;
  logic [WIDTH-1:0] phigh_q, phigh_d;
  logic             pend_q, pend_d;
  logic             clockout_d, period_done_d, active_d, cfg_err_d;

  logic xfer, legal, boundary, run_d;

  // Ready depends only on registered state, never on cfg_valid.
  assign cfg_ready = (state_q == StIdle) | ~pend_q;
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = (cfg_ratio >= Two) && (cfg_high != Zero) && (cfg_high < cfg_ratio);
  assign boundary  = (state_q != StIdle) && (cnt_q == ratio_q - One);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    high_d   = high_q;
    pratio_d = pratio_q;
    phigh_d  = phigh_q;
    pend_d   = pend_q;

    unique case (state_q)
      StIdle: begin
        // Nothing is emitting, so a legal configuration takes effect immediately.
        if (xfer && legal) begin
          ratio_d = cfg_ratio;
          high_d  = cfg_high;
        end
        cnt_d = Zero;
        if (enable) state_d = StRun;
      end
      StRun, StDrain: begin
        if (boundary) begin
          cnt_d = Zero;
          // Swap uses the pending slot as it stood before this edge; an acceptance on the
          // boundary cycle itself waits for the following boundary.
          if (pend_q) begin
            ratio_d = pratio_q;
            high_d  = phigh_q;
            pend_d  = 1'b0;
          end
          state_d = enable ? StRun : StIdle;
        end else begin
          cnt_d   = cnt_q + One;
          state_d = enable ? StRun : StDrain;
        end
        // Only reachable with pend_q low, since ready is ~pend_q here.
        if (xfer && legal) begin
          pend_d   = 1'b1;
          pratio_d = cfg_ratio;
          phigh_d  = cfg_high;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are derived from next state so they line up with the registered counter.
    run_d         = (state_d != StIdle);
    clockout_d    = run_d && (cnt_d < high_d);
    period_done_d = run_d && (cnt_d == ratio_d - One);
    active_d      = run_d;
    cfg_err_d     = xfer & ~legal;
  end

  always_ff @(posedge clockin or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= Zero;
      ratio_q     <= WIDTH'(DEF_RATIO);
      high_q      <= WIDTH'(DEF_HIGH);
      pratio_q    <= Zero;
      phigh_q     <= Zero;
      pend_q      <= 1'b0;
      clockout    <= 1'b0;
      period_done <= 1'b0;
      active      <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      high_q      <= high_d;
      pratio_q    <= pratio_d;
      phigh_q     <= phigh_d;
      pend_q      <= pend_d;
      clockout    <= clockout_d;
      period_done <= period_done_d;
      active      <= active_d;
      cfg_err     <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// Testbench for divider_scheduler: directed vector table, hand-written multi-cycle
// sequences, then randomized stimulus checked against a period-level reference model.
module tb_divider_scheduler;

  logic       clockin = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_ratio;
  logic [7:0] cfg_high;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clockout;
  logic       period_done;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  divider_scheduler #(
    .WIDTH    (8),
    .DEF_RATIO(2),
    .DEF_HIGH (1)
  ) dut (
    .clockin    (clockin),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ratio  (cfg_ratio),
    .cfg_high   (cfg_high),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clockout   (clockout),
    .period_done(period_done),
    .active     (active)
  );

  always #5 clockin = ~clockin;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: tracks position inside the current period, the (N,H) of that period
  // and a queue of accepted-but-not-yet-applied configurations.
  bit m_run;
  int m_pos, m_n, m_h;
  bit m_err;
  int q_n[$];
  int q_h[$];

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_n = 2; m_h = 1; m_err = 0;
    q_n.delete(); q_h.delete();
  endtask

  task automatic model_step();
    bit rdy, x, ok;
    int rn, rh;
    rn  = int'(cfg_ratio);
    rh  = int'(cfg_high);
    rdy = !m_run || (q_n.size() == 0);
    x   = cfg_valid && rdy;
    ok  = (rn >= 2) && (rh >= 1) && (rh < rn);
    m_err = x && !ok;
    if (m_run) begin
      if (m_pos == m_n - 1) begin
        if (q_n.size() > 0) begin
          m_n = q_n.pop_front();
          m_h = q_h.pop_front();
        end
        m_pos = 0;
        if (!enable) m_run = 0;
      end else begin
        m_pos++;
      end
      if (x && ok) begin
        q_n.push_back(rn);
        q_h.push_back(rh);
      end
    end else begin
      if (x && ok) begin
        m_n = rn;
        m_h = rh;
      end
      if (enable) begin
        m_run = 1;
        m_pos = 0;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    string s;
    s = $sformatf("rand%0d", cyc);
    chk({s, ".clockout"},    clockout,    m_run && (m_pos < m_h));
    chk({s, ".period_done"}, period_done, m_run && (m_pos == m_n - 1));
    chk({s, ".active"},      active,      m_run);
    chk({s, ".cfg_ready"},   cfg_ready,   !m_run || (q_n.size() == 0));
    chk({s, ".cfg_err"},     cfg_err,     m_err);
  endtask

  // Drive inputs, clock once, sample 1 ns after the edge.
  task automatic step(input logic en, input logic v, input logic [7:0] r, input logic [7:0] h,
                      input logic eclk, input logic epd, input logic eact, input string name);
    enable = en; cfg_valid = v; cfg_ratio = r; cfg_high = h;
    @(posedge clockin);
    #1;
    chk({name, ".clockout"},    clockout,    eclk);
    chk({name, ".period_done"}, period_done, epd);
    chk({name, ".active"},      active,      eact);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 0; cfg_valid = 0; cfg_ratio = 0; cfg_high = 0;
    repeat (2) @(posedge clockin);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] ratio;
    logic [7:0] high;
    logic       e_clk;
    logic       e_pd;
    logic       e_rdy;
    logic       e_err;
    logic       e_act;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // Load 5/2 in idle, run, offer illegal configs, then queue 3/1 on a boundary and stop.
    vecs[0]  = '{0, 1, 5, 2, 0, 0, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
    vecs[2]  = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 1, 0, 1};
    vecs[6]  = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
    vecs[7]  = '{1, 1, 4, 4, 1, 0, 1, 1, 1};
    vecs[8]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
    vecs[9]  = '{1, 1, 6, 0, 0, 0, 1, 1, 1};
    vecs[10] = '{1, 0, 0, 0, 0, 1, 1, 0, 1};
    vecs[11] = '{1, 1, 3, 1, 1, 0, 0, 0, 1};
    vecs[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[15] = '{1, 0, 0, 0, 0, 1, 0, 0, 1};
    vecs[16] = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
    vecs[17] = '{1, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[18] = '{1, 0, 0, 0, 0, 1, 1, 0, 1};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

    do_reset();
    chk("reset.clockout",    clockout,    1'b0);
    chk("reset.period_done", period_done, 1'b0);
    chk("reset.active",      active,      1'b0);
    chk("reset.cfg_err",     cfg_err,     1'b0);
    chk("reset.cfg_ready",   cfg_ready,   1'b1);

    // Default 2/1 after reset: toggles every cycle, period_done every second cycle.
    step(1, 0, 0, 0, 1, 0, 1, "def0");
    step(1, 0, 0, 0, 0, 1, 1, "def1");
    step(1, 0, 0, 0, 1, 0, 1, "def2");
    step(1, 0, 0, 0, 0, 1, 1, "def3");
    step(0, 0, 0, 0, 0, 0, 0, "def_stop");

    for (int i = 0; i < 20; i++) begin
      string s;
      s = $sformatf("vec%0d", i);
      enable = vecs[i].en; cfg_valid = vecs[i].valid;
      cfg_ratio = vecs[i].ratio; cfg_high = vecs[i].high;
      @(posedge clockin);
      #1;
      chk({s, ".clockout"},    clockout,    vecs[i].e_clk);
      chk({s, ".period_done"}, period_done, vecs[i].e_pd);
      chk({s, ".cfg_ready"},   cfg_ready,   vecs[i].e_rdy);
      chk({s, ".cfg_err"},     cfg_err,     vecs[i].e_err);
      chk({s, ".active"},      active,      vecs[i].e_act);
    end

    // 4/2: drop enable while cnt=1, the period finishes then goes idle.
    step(0, 1, 4, 2, 0, 0, 0, "drain_cfg");
    step(1, 0, 0, 0, 1, 0, 1, "drain_c0");
    step(1, 0, 0, 0, 1, 0, 1, "drain_c1");
    step(0, 0, 0, 0, 0, 0, 1, "drain_c2");
    step(0, 0, 0, 0, 0, 1, 1, "drain_c3");
    step(0, 0, 0, 0, 0, 0, 0, "drain_idle");
    step(0, 0, 0, 0, 0, 0, 0, "drain_idle2");
    // Re-raise during drain: no gap, no phase jump.
    step(1, 0, 0, 0, 1, 0, 1, "rerun_c0");
    step(1, 0, 0, 0, 1, 0, 1, "rerun_c1");
    step(0, 0, 0, 0, 0, 0, 1, "rerun_c2");
    step(1, 0, 0, 0, 0, 1, 1, "rerun_c3");
    step(1, 0, 0, 0, 1, 0, 1, "rerun_n0");
    step(1, 0, 0, 0, 1, 0, 1, "rerun_n1");
    step(0, 0, 0, 0, 0, 0, 1, "rerun_n2");
    step(0, 0, 0, 0, 0, 1, 1, "rerun_n3");
    step(0, 0, 0, 0, 0, 0, 0, "rerun_idle");

    // 8/4 with 3/1 pending, reset at cnt=3 clears everything immediately.
    step(0, 1, 8, 4, 0, 0, 0, "rst_cfg");
    step(1, 0, 0, 0, 1, 0, 1, "rst_c0");
    step(1, 1, 3, 1, 1, 0, 1, "rst_c1");
    step(1, 0, 0, 0, 1, 0, 1, "rst_c2");
    step(1, 0, 0, 0, 1, 0, 1, "rst_c3");
    chk("rst_c3.cfg_ready", cfg_ready, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid.clockout",  clockout,  1'b0);
    chk("rst_mid.active",    active,    1'b0);
    chk("rst_mid.cfg_ready", cfg_ready, 1'b1);
    enable = 0; cfg_valid = 0;
    @(posedge clockin);
    #1;
    reset = 1'b1;
    step(1, 0, 0, 0, 1, 0, 1, "post_rst0");
    step(1, 0, 0, 0, 0, 1, 1, "post_rst1");
    step(1, 0, 0, 0, 1, 0, 1, "post_rst2");
    step(1, 0, 0, 0, 0, 1, 1, "post_rst3");

    // Randomized stimulus against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      enable    = ($urandom_range(0, 9) < 8);
      cfg_valid = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 7) == 0) begin
        cfg_ratio = 8'($urandom_range(0, 255));
        cfg_high  = 8'($urandom_range(0, 255));
      end else begin
        cfg_ratio = 8'($urandom_range(0, 7));
        cfg_high  = 8'($urandom_range(0, 7));
      end
      @(posedge clockin);
      model_step();
      #1;
      model_check(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
